horizontal_tf_rom_writer: RTL and testbench
===========================================

// Module: horizontal_tf_rom_writer
// PURPOSE
//  Fills the eight horizontal twiddle ROM banks that the horizontal twiddle path reads.
//  For every row a in 0..DEPTH-1 it computes the row base w_a = omega^a mod N.
//  It then computes tf_j = w_a^j mod N for j=1..15 and writes them out:
//    bank0 word = tf1 (64b, zero-extended to 128b);
//    bank i (1..7) word = {tf(2i+1), tf(2i)} (128b).
//  One MulMod128 is time-shared serially. Runs once per start, after reset or a modulus/root change.
// PARAMETERS
//  P_WIDTH   64   modulus / twiddle width
//  SD_WIDTH  128  packed bank word width (2*P_WIDTH)
//  ADDR_W    10   ROM row address width; DEPTH = 1<<ADDR_W
//  MUL_LAT   4    cycles from operand issue to valid MulMod128 result; must equal the instantiated multiplier's depth
// PORTS
//  clk       in   1         clock
//  rst_n     in   1         synchronous active-low reset
//  start     in   1         1-cycle request; honoured only when busy=0
//  omega_in  in   P_WIDTH   root; sampled on accepted start; must be < N_in
//  N_in      in   P_WIDTH   modulus; sampled on accepted start; held stable while busy
//  busy      out  1         high from cycle after accepted start through last write
//  done      out  1         1-cycle pulse, cycle after final row completes
//  wr_en     out  1         1-cycle write strobe; no backpressure (ROM write always accepted)
//  wr_bank   out  3         target bank 0..7
//  wr_addr   out  ADDR_W    row address a
//  wr_data   out  SD_WIDTH  bank word as above; bank0 upper 64b = 0
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): FSM->IDLE; busy, done, wr_en = 0; wr_bank, wr_addr, wr_data = 0; counters cleared.
//  Reset mid-run aborts at once; no further writes; ROM contents are then partial/undefined.
//  FSM: IDLE -> ROW_W0 -> MUL_ISSUE -> MUL_WAIT -> (MUL_ISSUE | BASE_ISSUE) -> BASE_WAIT -> (ROW_W0 | FIN) -> IDLE.
//    IDLE: start=1 latches omega, N; w <- 1, a <- 0, j <- 1; go to ROW_W0.
//    ROW_W0 (1 cycle): wr_en=1, bank0, addr a, data {0,w}; p <- w; j <- 2.
//    MUL_ISSUE: drive MulMod128 A=p, B=w, N=N for one cycle.
//    MUL_WAIT: wait MUL_LAT cycles, then capture p <- S_out.
//      j even: hold p in lo_reg, no write.
//      j odd: wr_en=1, bank j>>1, data {p, lo_reg}.
//      j<15: j++ and re-issue; j=15: go to BASE_ISSUE.
//    BASE_ISSUE/BASE_WAIT: multiply w*omega the same way; capture w <- S_out.
//      a<DEPTH-1: a++, go to ROW_W0; else go to FIN.
//      The last row still performs the base multiply; its result is discarded.
//    FIN: done=1 for one cycle; busy=0 from that cycle; go to IDLE.
//  Timing:
//    Each multiply occupies MUL_LAT+1 cycles (issue + MUL_LAT).
//    Row = 1 + 15*(MUL_LAT+1) cycles (76 at default).
//    done asserts DEPTH*(1+15*(MUL_LAT+1)) + 1 cycles after the accepted start cycle.
//  Per row, writes are issued in bank order 0,1,...,7. Exactly 8*DEPTH writes per run.
//  start while busy: ignored, no side effect. start in the FIN cycle: ignored.
//  Arithmetic: all values stay < N because MulMod128 reduces mod N. Row 0 writes tf_j = 1 for all j.
//  Out-of-range omega_in (>= N_in) is illegal; the output is unspecified.
// STRUCTURE
//  Shared include horizontal_params.vh holds:
//    NUM_TF=15, NUM_BANK=8;
//    bank width constants P_WIDTH/SD_WIDTH;
//    FSM state encodings (3b).
//  One sub-module: the existing MulMod128 (mul_tf_gen0).
//  Its operand registers are held stable during MUL_WAIT.
//  All other logic is local: FSM, j counter (4b), latency counter, a counter (ADDR_W), and the w, p, lo_reg and omega/N registers.
// TESTING
//  Reset: assert rst_n=0 mid-run (row 1, j=7) -> next cycle wr_en=0, busy=0; a new start restarts from row 0.
//  N=17, omega=3, ADDR_W=2, start ->
//    row0: every bank word holds only 1s (bank0 data=1; banks1-7 = {1,1});
//    row1: bank0=3, bank1={10,9}, bank7={3^15 mod17=6, 3^14 mod17=2};
//    row2: bank0=9.
//  Same run: done asserts exactly 4*76+1=305 cycles after start; 32 wr_en pulses total; busy low after done.
//  start pulsed again while busy (row 2) -> ignored; the write sequence and done timing are unchanged.
//  N=2^61-1, omega = random < N, ADDR_W=3 -> every written tf matches the reference model omega^(a*j) mod N.
//  Back-to-back runs: second start with new N=97, omega=5 -> row1 bank0=5, bank1={28,25}; no stale values from the first run.

Source files
------------

// File: rtl/horizontal_tf_rom_writer_pkg.sv
// horizontal_tf_rom_writer_pkg: shared widths, table sizes and FSM encoding for the twiddle ROM writer
package horizontal_tf_rom_writer_pkg;
    localparam int DEF_P_WIDTH  = 64;
    localparam int DEF_SD_WIDTH = 128;
    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_MUL_LAT  = 4;
    localparam int NUM_TF       = 15;
    localparam int NUM_BANK     = 8;
    typedef enum logic [2:0] {
        IDLE,
        ROW_W0,
        MUL_ISSUE,
        MUL_WAIT,
        BASE_ISSUE,
        BASE_WAIT,
        FIN
    } state_t;
endpackage

// File: rtl/horizontal_tf_rom_writer_mulmod.sv
// horizontal_tf_rom_writer_mulmod: pipelined modular multiplier, s = a*b mod n valid LAT cycles after issue
module horizontal_tf_rom_writer_mulmod #(
    parameter int W   = 64,
    parameter int LAT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic [W-1:0] s
);
    logic [2*W-1:0] prod;
    logic [2*W-1:0] wide_n;
    logic [W-1:0]   rem;
    logic [W-1:0]   pipe [LAT];
    assign prod   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    assign wide_n = {{W{1'b0}}, n};
    assign rem    = (n == '0) ? '0 : W'(prod % wide_n);
    // delay the reduced product so it appears exactly LAT cycles after issue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= rem;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign s = pipe[LAT-1];
endmodule

// File: rtl/horizontal_tf_rom_writer.sv
// horizontal_tf_rom_writer: fills the eight horizontal twiddle ROM banks with omega^(a*j) mod N
module horizontal_tf_rom_writer
    import horizontal_tf_rom_writer_pkg::*;
#(
    parameter int P_WIDTH  = DEF_P_WIDTH,
    parameter int SD_WIDTH = DEF_SD_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int MUL_LAT  = DEF_MUL_LAT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [P_WIDTH-1:0]  omega_in,
    input  logic [P_WIDTH-1:0]  N_in,
    output logic                busy,
    output logic                done,
    output logic                wr_en,
    output logic [2:0]          wr_bank,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [SD_WIDTH-1:0] wr_data
);
    localparam int LW = $clog2(MUL_LAT) + 1;
    state_t             state, state_next;
    logic [P_WIDTH-1:0] omega, n, w, p, lo, op_a, op_b, s_out;
    logic [ADDR_W-1:0]  a;
    logic [3:0]         j;
    logic [LW-1:0]      lat;
    logic               lat_done, base_op, odd_write, last_tf;
    assign lat_done  = lat == LW'(MUL_LAT - 1);
    assign last_tf   = j == 4'(NUM_TF);
    assign base_op   = state inside {BASE_ISSUE, BASE_WAIT};
    assign odd_write = state == MUL_WAIT && lat_done && j[0];
    assign op_a      = base_op ? w : p;
    assign op_b      = base_op ? omega : w;
    horizontal_tf_rom_writer_mulmod #(.W(P_WIDTH), .LAT(MUL_LAT)) mul_tf_gen0 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (op_a),
        .b     (op_b),
        .n     (n),
        .s     (s_out)
    );
    // state register
    always_ff @(posedge clk) state <= !rst_n ? IDLE : state_next;
    // sequencing through row base write, 14 power multiplies and the base advance multiply
    always_comb begin
        state_next = state;
        busy       = state != IDLE && state != FIN;
        done       = state == FIN;
        wr_en      = state == ROW_W0 || odd_write;
        wr_bank    = odd_write ? j[3:1] : 3'd0;
        wr_addr    = wr_en ? a : '0;
        wr_data    = odd_write ? {s_out, lo} : (state == ROW_W0) ? SD_WIDTH'(w) : '0;
        case (state)
            IDLE:       state_next = start ? ROW_W0 : IDLE;
            ROW_W0:     state_next = MUL_ISSUE;
            MUL_ISSUE:  state_next = MUL_WAIT;
            MUL_WAIT:   state_next = !lat_done ? MUL_WAIT : last_tf ? BASE_ISSUE : MUL_ISSUE;
            BASE_ISSUE: state_next = BASE_WAIT;
            BASE_WAIT:  state_next = !lat_done ? BASE_WAIT : (&a) ? FIN : ROW_W0;
            default:    state_next = IDLE;
        endcase
    end
    // datapath: operand latch, running power p, even-power holding register, row base and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            omega <= '0;
            n     <= '0;
            w     <= '0;
            p     <= '0;
            lo    <= '0;
            a     <= '0;
            j     <= '0;
            lat   <= '0;
        end else begin
            lat <= (state inside {MUL_WAIT, BASE_WAIT}) && !lat_done ? lat + 1'b1 : '0;
            if (state == IDLE && start) begin
                omega <= omega_in;
                n     <= N_in;
                w     <= P_WIDTH'(1);
                a     <= '0;
                j     <= 4'd1;
            end
            if (state == ROW_W0) begin
                p <= w;
                j <= 4'd2;
            end
            if (state == MUL_WAIT && lat_done) begin
                p <= s_out;
                if (!j[0]) lo <= s_out;
                if (!last_tf) j <= j + 4'd1;
            end
            if (state == BASE_WAIT && lat_done) begin
                w <= s_out;
                a <= a + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_horizontal_tf_rom_writer.sv
// tb_horizontal_tf_rom_writer: randomized and directed checks of the twiddle ROM writer against a modpow model
module tb_horizontal_tf_rom_writer;
    logic         clk = 0, rst_n = 0, st2 = 0, st3 = 0;
    logic [63:0]  omega_in = 0, n_in = 0;
    logic         busy2, done2, wr_en2, busy3, done3, wr_en3;
    logic [2:0]   bank2, bank3, addr3;
    logic [1:0]   addr2;
    logic [127:0] data2, data3;
    int           n_chk = 0, n_fail = 0;
    typedef struct packed {
        logic [2:0]   bank;
        logic [2:0]   addr;
        logic [127:0] data;
    } wr_t;
    wr_t q[$];

    always #5 clk = ~clk;

    horizontal_tf_rom_writer #(.ADDR_W(2)) d2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .omega_in(omega_in), .N_in(n_in),
        .busy(busy2), .done(done2), .wr_en(wr_en2), .wr_bank(bank2), .wr_addr(addr2), .wr_data(data2)
    );
    horizontal_tf_rom_writer #(.ADDR_W(3)) d3 (
        .clk(clk), .rst_n(rst_n), .start(st3), .omega_in(omega_in), .N_in(n_in),
        .busy(busy3), .done(done3), .wr_en(wr_en3), .wr_bank(bank3), .wr_addr(addr3), .wr_data(data3)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pw(input logic [63:0] b, input int unsigned e, input logic [63:0] nn);
        logic [127:0] r, x, m;
        m = {64'd0, nn};
        r = 128'd1;
        x = {64'd0, b} % m;
        while (e != 0) begin
            if (e[0]) r = (r * x) % m;
            x = (x * x) % m;
            e = e >> 1;
        end
        return r[63:0];
    endfunction

    function automatic logic [127:0] exp_word(input int a, input int b, input logic [63:0] om, input logic [63:0] nn);
        logic [63:0] w;
        w = pw(om, a, nn);
        if (b == 0) return {64'd0, pw(w, 1, nn)};
        return {pw(w, 2 * b + 1, nn), pw(w, 2 * b, nn)};
    endfunction

    task automatic run(input bit sel, input logic [63:0] om, input logic [63:0] nn, input bit stray);
        int  depth, c;
        bit  seen;
        depth = sel ? 8 : 4;
        seen  = 0;
        q.delete();
        @(negedge clk);
        omega_in = om;
        n_in     = nn;
        st2      = !sel;
        st3      = sel;
        for (c = 1; c <= 3000 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) chk("busy_on", sel ? busy3 : busy2, 1);
            if (sel ? wr_en3 : wr_en2)
                q.push_back(sel ? {bank3, addr3, data3} : {bank2, 1'b0, addr2, data2});
            if (sel ? done3 : done2) begin
                seen = 1;
                chk("done_cycle", c, depth * 76 + 1);
                chk("busy_at_done", sel ? busy3 : busy2, 0);
            end
            st2      = 0;
            st3      = 0;
            omega_in = om;
            if (stray && c == 2 * 76 + 20) begin
                st2      = !sel;
                st3      = sel;
                omega_in = {$urandom, $urandom};
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_pulse", sel ? done3 : done2, 0);
        chk("busy_off", sel ? busy3 : busy2, 0);
        chk("wr_count", q.size(), depth * 8);
        for (int i = 0; i < q.size() && i < depth * 8; i++) begin
            chk("wr_bank", q[i].bank, i % 8);
            chk("wr_addr", q[i].addr, i / 8);
            chk("wr_data", q[i].data, exp_word(i / 8, i % 8, om, nn));
        end
    endtask

    initial begin
        logic [63:0] n61, r;
        int          wcount;
        n61 = 64'h1FFF_FFFF_FFFF_FFFF;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy2, 0);
        chk("rst_done", done2, 0);
        chk("rst_wr_en", wr_en2, 0);
        chk("rst_wr_data", data2, 0);
        chk("rst_wr_bank", bank2, 0);
        chk("rst_wr_addr", addr2, 0);
        chk("rst_busy3", busy3, 0);
        rst_n = 1;
        run(0, 64'd3, 64'd17, 1);
        chk("r0_bank0", q[0].data, 128'd1);
        for (int b = 1; b < 8; b++) chk("r0_bankn", q[b].data, {64'd1, 64'd1});
        chk("r1_bank0", q[8].data, 128'd3);
        chk("r1_bank1", q[9].data, {64'd10, 64'd9});
        chk("r1_bank7", q[15].data, {64'd6, 64'd2});
        chk("r2_bank0", q[16].data, 128'd9);
        run(0, 64'd5, 64'd97, 0);
        chk("b2b_r1_bank0", q[8].data, 128'd5);
        chk("b2b_r1_bank1", q[9].data, {64'd28, 64'd25});
        @(negedge clk);
        omega_in = 3;
        n_in     = 17;
        st2      = 1;
        @(negedge clk);
        st2 = 0;
        repeat (103) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("midrst_wr_en", wr_en2, 0);
        chk("midrst_busy", busy2, 0);
        chk("midrst_wr_data", data2, 0);
        rst_n  = 1;
        wcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_en2 || busy2) wcount++;
        end
        chk("midrst_quiet", wcount, 0);
        run(0, 64'd3, 64'd17, 0);
        repeat (2) begin
            r = {$urandom, $urandom};
            run(1, r % n61, n61, 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
